// File: rtl/mult_result_collector.sv
// ============================================================================
// Module   : mult_result_collector
// Purpose  : Assembles 16-bit Multiplier products from byte strobes into a FIFO
//            drained by valid/ready. Optional MULT_COLLECTOR_ACCUM_EN sums pops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_result_collector #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    databus,
    input  logic          lsb_out,
    input  logic          msb_out,
    input  logic          done,
    output logic [15:0]   res_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          proto_err,
    output logic [23:0]   acc_sum
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        WAIT_LSB  = 2'd0,
        WAIT_MSB  = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t        r_state, w_next_state;
    logic [7:0]    r_lo, r_hi;
    logic          w_cap_lo, w_cap_hi, w_push, w_err;
    logic [15:0]   w_push_data;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_next;
    logic [CW-1:0] w_count_next;
    logic          w_pop, w_full, w_push_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT_LSB;
            r_lo    <= 8'h00;
            r_hi    <= 8'h00;
        end else begin
            r_state <= w_next_state;
            if (w_cap_lo) r_lo <= databus;
            if (w_cap_hi) r_hi <= databus;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cap_lo     = 1'b0;
        w_cap_hi     = 1'b0;
        w_push       = 1'b0;
        w_err        = 1'b0;
        w_push_data  = {r_hi, r_lo};
        if (lsb_out && msb_out) begin
            w_err        = 1'b1;
            w_next_state = WAIT_LSB;
        end else begin
            case (r_state)
                WAIT_LSB: begin
                    if (lsb_out) begin
                        w_cap_lo     = 1'b1;
                        w_next_state = WAIT_MSB;
                    end else if (msb_out) begin
                        w_err = 1'b1;
                    end
                end
                WAIT_MSB: begin
                    if (msb_out && done) begin
                        // Merged strobe: bypass the hi register entirely.
                        w_push       = 1'b1;
                        w_push_data  = {databus, r_lo};
                        w_next_state = WAIT_LSB;
                    end else if (msb_out) begin
                        w_cap_hi     = 1'b1;
                        w_next_state = WAIT_DONE;
                    end else if (lsb_out) begin
                        w_err    = 1'b1;
                        w_cap_lo = 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (lsb_out) begin
                        w_err        = 1'b1;
                        w_cap_lo     = 1'b1;
                        w_next_state = WAIT_MSB;
                    end else if (msb_out) begin
                        w_err        = 1'b1;
                        w_next_state = WAIT_LSB;
                    end else if (done) begin
                        w_push       = 1'b1;
                        w_next_state = WAIT_LSB;
                    end
                end
                default: w_next_state = WAIT_LSB;
            endcase
        end
    end

    assign w_pop     = res_valid && res_ready;
    assign w_full    = (count == FULL_CNT);
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_rd_next = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

    always_comb begin
        w_count_next = count;
        case ({w_push_ok, w_pop})
            2'b10:   w_count_next = count + 1'b1;
            2'b01:   w_count_next = count - 1'b1;
            default: w_count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            count     <= '0;
            res_valid <= 1'b0;
            res_data  <= 16'h0000;
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rd_ptr  <= w_rd_next;
            count     <= w_count_next;
            res_valid <= (w_count_next != '0);
            // Next head may be the entry being written this very edge.
            if (w_count_next != '0)
                res_data <= (w_push_ok && (r_wr_ptr == w_rd_next)) ? w_push_data
                                                                     : r_mem[w_rd_next];
            if (w_push && !w_push_ok) overflow <= 1'b1;
            if (w_err) proto_err <= 1'b1;
        end
    end

`ifdef MULT_COLLECTOR_ACCUM_EN
    logic [23:0] r_acc;
    always_ff @(posedge clk) begin
        if (rst)        r_acc <= 24'h0;
        else if (w_pop) r_acc <= r_acc + {8'h00, res_data};
    end
    assign acc_sum = r_acc;
`else
    assign acc_sum = 24'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mult_result_collector.sv
// ============================================================================
// Module   : tb_mult_result_collector
// Purpose  : Directed self-checking bench for mult_result_collector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_result_collector;

`ifdef MULT_COLLECTOR_ACCUM_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  databus = 8'h00;
    logic        lsb_out = 1'b0, msb_out = 1'b0, done = 1'b0, res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_valid, overflow, proto_err;
    logic [2:0]  count;
    logic [23:0] acc_sum;

    int vectors = 0;
    int miscompares = 0;

    mult_result_collector #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .databus(databus),
        .lsb_out(lsb_out), .msb_out(msb_out), .done(done),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .count(count), .overflow(overflow), .proto_err(proto_err),
        .acc_sum(acc_sum)
    );

    always #5 clk = ~clk;

    task automatic step(input logic l, input logic m, input logic d,
                        input logic [7:0] b, input logic r);
        lsb_out = l; msb_out = m; done = d; databus = b; res_ready = r;
        @(posedge clk);
        #1;
        lsb_out = 1'b0; msb_out = 1'b0; done = 1'b0; res_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic product(input logic [7:0] hi, input logic [7:0] lo);
        step(1'b1, 1'b0, 1'b0, lo, 1'b0);
        step(1'b0, 1'b1, 1'b0, hi, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    endtask

    initial begin
        logic [15:0] exp_q [4];

        do_reset();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_valid", res_valid, 0);
        chk("rst_data", res_data, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_perr", proto_err, 0);
        chk("rst_acc", acc_sum, 0);

        // Basic product
        product(8'h12, 8'h34);
        chk("basic_valid", res_valid, 1);
        chk("basic_data", res_data, 16'h1234);
        chk("basic_count", count, 1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("basic_pop_count", count, 0);
        chk("basic_pop_valid", res_valid, 0);
        chk("basic_acc", acc_sum, ACC ? 24'h001234 : 24'h0);
        chk("basic_perr", proto_err, 0);

        // Overflow with five products into a 4-deep FIFO
        for (int k = 1; k <= 5; k++) product(8'(k), 8'(k));
        chk("ovf_count", count, 4);
        chk("ovf_flag", overflow, 1);
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_drain_valid", res_valid, 1);
            chk("ovf_drain_data", res_data, {8'(k), 8'(k)});
            step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        end
        chk("ovf_empty_valid", res_valid, 0);
        chk("ovf_empty_count", count, 0);
        chk("ovf_acc", acc_sum, ACC ? 24'h001C3E : 24'h0);

        // Full FIFO, push coincides with pop
        do_reset();
        product(8'h11, 8'h11);
        product(8'h22, 8'h22);
        product(8'h33, 8'h33);
        product(8'h44, 8'h44);
        chk("full_count", count, 4);
        step(1'b1, 1'b0, 1'b0, 8'h55, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h55, 1'b0);
        chk("full_hold_data", res_data, 16'h1111);
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        chk("fullpop_count", count, 4);
        chk("fullpop_ovf", overflow, 0);
        exp_q = '{16'h2222, 16'h3333, 16'h4444, 16'h5555};
        for (int k = 0; k < 4; k++) begin
            chk("fullpop_drain", res_data, exp_q[k]);
            step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        end
        chk("fullpop_empty", res_valid, 0);
        chk("fullpop_acc", acc_sum, ACC ? 24'h00FFFF : 24'h0);

        // Protocol errors
        do_reset();
        step(1'b0, 1'b1, 1'b0, 8'h77, 1'b0);
        chk("perr_msb_flag", proto_err, 1);
        chk("perr_msb_count", count, 0);
        chk("perr_msb_valid", res_valid, 0);
        step(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);
        chk("merged_data", res_data, 16'hFFFF);
        chk("merged_count", count, 1);
        step(1'b1, 1'b1, 1'b0, 8'hAB, 1'b1);
        chk("both_count", count, 0);
        step(1'b0, 1'b1, 1'b1, 8'hCD, 1'b0);
        chk("both_nocapture", count, 0);

        // Reset mid-operation
        do_reset();
        step(1'b1, 1'b0, 1'b0, 8'hAA, 1'b0);
        do_reset();
        step(1'b0, 1'b1, 1'b0, 8'h12, 1'b0);
        chk("midrst_perr", proto_err, 1);
        chk("midrst_count", count, 0);
        chk("midrst_ovf", overflow, 0);
        chk("midrst_valid", res_valid, 0);

        // Accumulator
        do_reset();
        product(8'h80, 8'h00);
        product(8'h90, 8'h00);
        chk("acc_head", res_data, 16'h8000);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("acc_second", res_data, 16'h9000);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("acc_sum", acc_sum, ACC ? 24'h011000 : 24'h0);
        chk("acc_empty", res_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
